// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back slice.
package rf_pkg;

    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int NREGS    = 32;
    localparam int REG_ZERO = 0;

    // One buffered long-latency result: destination register plus value.
    typedef struct packed {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } wb_entry_t;

    // One-hot select of a register; register 0 never selects anything.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [AW-1:0] idx);
        logic [NREGS-1:0] v;
        v = '0;
        if (idx != AW'(REG_ZERO)) v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular FIFO of write-back entries holding long-latency results until the
// single register-file write port is free. Pointers wrap modulo DEPTH, which
// must be a power of two.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     push_entry,
    input  logic          pop,
    output wb_entry_t     head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset flushes every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-side controller for the 32x32 register file. ALU results take the
// single write port first; long-latency results queue in rf_wb_fifo and drain
// when the ALU is idle. A busy scoreboard tracks in-flight long-latency
// destinations for decode's RAW stall.
// Optional build macro RF_WB_BYPASS_EN: an LU result arriving while the FIFO
// is empty and the ALU is idle is written straight to the output registers.
module rf_wb_ctrl
    import rf_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  DW    = 32,
    parameter int  AW    = 5,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_reg,
    input  logic [DW-1:0] alu_data,
    input  logic          lu_valid,
    output logic          lu_ready,
    input  logic [AW-1:0] lu_reg,
    input  logic [DW-1:0] lu_data,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_reg,
    output logic [31:0]   busy,
    output logic          rf_write,
    output logic [AW-1:0] rf_write_reg,
    output logic [DW-1:0] rf_write_data,
    output logic [CW-1:0] fifo_count
);

    wb_entry_t     lu_entry;
    wb_entry_t     fifo_head;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          bypass;
    logic          win_valid;
    logic [AW-1:0] win_reg;
    logic [DW-1:0] win_data;
    logic [31:0]   clr_vec;
    logic [31:0]   set_vec;
    logic [31:0]   busy_next;

    assign lu_entry = '{dst: lu_reg, data: lu_data};

    // Full comes from the registered count only, so a same-cycle pop never
    // opens a slot early.
    assign lu_ready = !fifo_full;

`ifdef RF_WB_BYPASS_EN
    assign bypass = fifo_empty && !alu_valid && lu_valid;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = lu_valid && lu_ready && !bypass;
    assign fifo_pop  = !alu_valid && !fifo_empty;

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (lu_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Fixed-priority pick of this cycle's write: ALU, then FIFO head, then bypass.
    always_comb begin
        win_valid = 1'b0;
        win_reg   = '0;
        win_data  = '0;
        clr_vec   = '0;
        if (alu_valid) begin
            win_valid = 1'b1;
            win_reg   = alu_reg;
            win_data  = alu_data;
        end else if (!fifo_empty) begin
            win_valid = 1'b1;
            win_reg   = fifo_head.dst;
            win_data  = fifo_head.data;
            clr_vec   = reg_onehot(fifo_head.dst);
        end else if (bypass) begin
            win_valid = 1'b1;
            win_reg   = lu_reg;
            win_data  = lu_data;
            clr_vec   = reg_onehot(lu_reg);
        end
    end

    // A new issue overrides a retiring result for the same register.
    assign set_vec   = issue_valid ? reg_onehot(issue_reg) : '0;
    assign busy_next = (busy & ~clr_vec) | set_vec;

    // Registered write port and scoreboard; register 0 writes are swallowed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_write      <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            busy          <= '0;
        end else begin
            rf_write <= win_valid && (win_reg != AW'(REG_ZERO));
            if (win_valid) begin
                rf_write_reg  <= win_reg;
                rf_write_data <= win_data;
            end
            busy <= busy_next;
        end
    end

    // Decode must not re-issue to a register still in flight, unless its
    // result retires on this very edge.
    always_ff @(posedge clk) begin
        if (rst && issue_valid && (issue_reg != AW'(REG_ZERO)))
            assert (!busy[issue_reg] || clr_vec[issue_reg]);
    end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: directed scenarios followed by random traffic, all
// compared against a queue-based reference model of the write-back rules.
module tb_rf_wb_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic [4:0]    alu_reg;
    logic [31:0]   alu_data;
    logic          lu_valid;
    logic          lu_ready;
    logic [4:0]    lu_reg;
    logic [31:0]   lu_data;
    logic          issue_valid;
    logic [4:0]    issue_reg;
    logic [31:0]   busy;
    logic          rf_write;
    logic [4:0]    rf_write_reg;
    logic [31:0]   rf_write_data;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    rf_wb_ctrl #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_reg       (alu_reg),
        .alu_data      (alu_data),
        .lu_valid      (lu_valid),
        .lu_ready      (lu_ready),
        .lu_reg        (lu_reg),
        .lu_data       (lu_data),
        .issue_valid   (issue_valid),
        .issue_reg     (issue_reg),
        .busy          (busy),
        .rf_write      (rf_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .fifo_count    (fifo_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending long-latency results as a queue, busy as a set.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_busy = '0;
    logic        m_wr   = 1'b0;
    logic [4:0]  m_reg  = '0;
    logic [31:0] m_data = '0;

    task automatic model_step();
        ent_t        e;
        bit          ready;
        bit          byp;
        bit          wv;
        logic [4:0]  wr;
        logic [31:0] wd;
        if (!rst) begin
            q.delete();
            m_busy = '0;
            m_wr   = 1'b0;
            m_reg  = '0;
            m_data = '0;
            return;
        end
        ready = (q.size() < DEPTH);
        byp   = BYP && (q.size() == 0) && !alu_valid && lu_valid;
        wv = 1'b0; wr = '0; wd = '0;
        if (alu_valid) begin
            wv = 1'b1; wr = alu_reg; wd = alu_data;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            wv = 1'b1; wr = e.r; wd = e.d;
            if (e.r != 0) m_busy[e.r] = 1'b0;
        end else if (byp) begin
            wv = 1'b1; wr = lu_reg; wd = lu_data;
            if (lu_reg != 0) m_busy[lu_reg] = 1'b0;
        end
        if (lu_valid && ready && !byp) begin
            e.r = lu_reg; e.d = lu_data;
            q.push_back(e);
        end
        if (issue_valid && issue_reg != 0) m_busy[issue_reg] = 1'b1;
        m_wr = wv && (wr != 0);
        if (wv) begin
            m_reg  = wr;
            m_data = wd;
        end
    endtask

    // One clock: advance the model with the sampled inputs, then compare.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("m_rf_write", {31'd0, rf_write}, {31'd0, m_wr});
        check("m_rf_write_reg", {27'd0, rf_write_reg}, {27'd0, m_reg});
        check("m_rf_write_data", rf_write_data, m_data);
        check("m_busy", busy, m_busy);
        check("m_fifo_count", 32'(fifo_count), 32'(q.size()));
        check("m_lu_ready", {31'd0, lu_ready}, {31'd0, (q.size() < DEPTH)});
    endtask

    task automatic set_idle();
        alu_valid   = 1'b0; alu_reg = '0; alu_data = '0;
        lu_valid    = 1'b0; lu_reg  = '0; lu_data  = '0;
        issue_valid = 1'b0; issue_reg = '0;
    endtask

    initial begin
        logic [4:0] pick;
        bit         found;

        rst = 1'b0;
        set_idle();
        cyc();
        cyc();
        check("rst_rf_write", {31'd0, rf_write}, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_lu_ready", {31'd0, lu_ready}, 32'd1);

        // 1: single ALU write
        rst = 1'b1;
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hDEADBEEF;
        cyc();
        check("t1_wr", {31'd0, rf_write}, 32'd1);
        check("t1_reg", {27'd0, rf_write_reg}, 32'd3);
        check("t1_data", rf_write_data, 32'hDEADBEEF);
        set_idle();
        cyc();
        check("t1_wr_drop", {31'd0, rf_write}, 32'd0);

        // 2: issue then LU result for reg 8
        issue_valid = 1'b1; issue_reg = 5'd8;
        cyc();
        check("t2_busy_set", {31'd0, busy[8]}, 32'd1);
        set_idle();
        lu_valid = 1'b1; lu_reg = 5'd8; lu_data = 32'h12345678;
        cyc();
        set_idle();
`ifdef RF_WB_BYPASS_EN
        check("t2_byp_wr", {31'd0, rf_write}, 32'd1);
        check("t2_byp_reg", {27'd0, rf_write_reg}, 32'd8);
        check("t2_byp_busy", {31'd0, busy[8]}, 32'd0);
        check("t2_byp_count", 32'(fifo_count), 32'd0);
        cyc();
`else
        check("t2_wait_wr", {31'd0, rf_write}, 32'd0);
        check("t2_busy_held", {31'd0, busy[8]}, 32'd1);
        cyc();
        check("t2_wr", {31'd0, rf_write}, 32'd1);
        check("t2_reg", {27'd0, rf_write_reg}, 32'd8);
        check("t2_data", rf_write_data, 32'h12345678);
        check("t2_busy_clr", {31'd0, busy[8]}, 32'd0);
`endif

        // 3: fill FIFO under continuous ALU traffic, then drain in order
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_reg = 5'(20 + i); alu_data = $urandom;
            lu_valid  = 1'b1; lu_reg  = 5'(10 + i); lu_data  = 32'hA000 + i;
            cyc();
            check("t3_alu_wr", {31'd0, rf_write}, 32'd1);
            check("t3_alu_reg", {27'd0, rf_write_reg}, 32'(20 + i));
        end
        check("t3_full_count", 32'(fifo_count), 32'd4);
        check("t3_full_ready", {31'd0, lu_ready}, 32'd0);
        alu_valid = 1'b1; alu_reg = 5'd24; lu_valid = 1'b1; lu_reg = 5'd30; lu_data = 32'hBAD;
        cyc();
        check("t3_drop_count", 32'(fifo_count), 32'd4);
        set_idle();
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t3_drain_wr", {31'd0, rf_write}, 32'd1);
            check("t3_drain_reg", {27'd0, rf_write_reg}, 32'(10 + i));
            check("t3_drain_data", rf_write_data, 32'hA000 + i);
        end
        check("t3_empty", 32'(fifo_count), 32'd0);

        // 4: register-0 results from both sources
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h1111;
        lu_valid  = 1'b1; lu_reg  = 5'd0; lu_data  = 32'h2222;
        cyc();
        check("t4_alu_r0", {31'd0, rf_write}, 32'd0);
        check("t4_count1", 32'(fifo_count), 32'd1);
        set_idle();
        cyc();
        check("t4_lu_r0", {31'd0, rf_write}, 32'd0);
        check("t4_count0", 32'(fifo_count), 32'd0);

        // 5: reset mid-operation
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'(i);
            lu_valid  = 1'b1; lu_reg  = 5'(14 + i); lu_data = 32'hC0 + i;
            issue_valid = (i == 0); issue_reg = 5'd5;
            cyc();
        end
        check("t5_count3", 32'(fifo_count), 32'd3);
        check("t5_busy5", {31'd0, busy[5]}, 32'd1);
        set_idle();
        rst = 1'b0;
        cyc();
        check("t5_rst_count", 32'(fifo_count), 32'd0);
        check("t5_rst_busy", busy, 32'd0);
        check("t5_rst_wr", {31'd0, rf_write}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t5_no_stale", {31'd0, rf_write}, 32'd0);
        end

        // 6: issue and retire of reg 9 on the same edge
        issue_valid = 1'b1; issue_reg = 5'd9;
        cyc();
        set_idle();
        alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 32'h5;
        lu_valid  = 1'b1; lu_reg  = 5'd9; lu_data  = 32'h99;
        cyc();
        check("t6_queued", 32'(fifo_count), 32'd1);
        set_idle();
        issue_valid = 1'b1; issue_reg = 5'd9;
        cyc();
        set_idle();
        check("t6_wr", {31'd0, rf_write}, 32'd1);
        check("t6_reg", {27'd0, rf_write_reg}, 32'd9);
        check("t6_busy_kept", {31'd0, busy[9]}, 32'd1);

        // Random traffic against the model
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            rst       = ($urandom_range(0, 99) != 0);
            alu_valid = ($urandom_range(0, 9) < 4);
            alu_reg   = 5'($urandom);
            alu_data  = $urandom;
            lu_valid  = ($urandom_range(0, 1) == 1);
            lu_data   = $urandom;
            lu_reg    = 5'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int t = 0; t < 8; t++) begin
                    pick = 5'($urandom);
                    if (m_busy[pick]) begin
                        lu_reg = pick;
                        break;
                    end
                end
            end
            issue_valid = 1'b0;
            issue_reg   = '0;
            if ($urandom_range(0, 9) < 3) begin
                found = 1'b0;
                for (int t = 0; t < 8 && !found; t++) begin
                    pick = 5'($urandom_range(1, 31));
                    if (!m_busy[pick]) found = 1'b1;
                end
                if (found) begin
                    issue_valid = 1'b1;
                    issue_reg   = pick;
                end
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
